config_manager_multi: RTL and testbench

Parametrised configuration controller with integrated datapath. It receives NUM_TEMP temperature thresholds followed by one humidity limit as a sequence of parity-checked serial words. Words are held in shadow registers, and the full set is committed atomically to the active limit registers only after every word is accepted. It sits between the serial receiver (word strobe, data, parity flag) and the climate-control datapath that consumes the limits.

---
 rtl/config_manager_multi.sv | 199 +++++++++++++++++++
 tb/tb_config_manager_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_manager_multi.sv
// config_manager_multi: collects NUM_TEMP temperature thresholds plus one humidity
// limit as parity-checked serial words into shadow registers, then commits the whole
// set atomically to the active limit registers once every word has been accepted.
// Optional inter-word timeout watchdog: define CONFIG_TIMEOUT_EN to build it.
module config_manager_multi #(
    parameter int NUM_TEMP       = 7,
    parameter int WORD_W         = 8,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              receber_config,
    input  logic                              word_valid,
    input  logic [WORD_W-1:0]                 word_data,
    input  logic                              parity_ok,
    output logic [NUM_TEMP*WORD_W-1:0]        temp_limits,
    output logic [WORD_W-1:0]                 lim_um,
    output logic                              config_valid,
    output logic                              pronto_config,
    output logic                              erro_config,
    output logic [1:0]                        erro_code,
    output logic [$clog2(NUM_TEMP+1)-1:0]     word_index,
    output logic [3:0]                        db_estado
);

    localparam int IDX_W = $clog2(NUM_TEMP + 1);

    typedef enum logic [1:0] {
        INICIAL = 2'd0,
        RECEBE  = 2'd1,
        COMMIT  = 2'd2,
        ERRO    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          wordIndex_q, wordIndex_d;
    logic [1:0]                erroCode_q, erroCode_d;
    logic                      pronto_q;
    logic                      configValid_q;
    logic [WORD_W-1:0]         shadowTemp_q [NUM_TEMP];
    logic [WORD_W-1:0]         shadowUm_q;
    logic [NUM_TEMP*WORD_W-1:0] activeTemp_q;
    logic [WORD_W-1:0]         activeUm_q;
    logic [WORD_W-1:0]         prevWord;
    logic                      shadowWe;
    logic                      shadowUmWe;
    logic                      commitNow;

`ifdef CONFIG_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timerExpired;

    assign timerExpired = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts idle cycles in RECEBE; restarts on frame (re)start and on each accepted word
    always_comb begin
        timer_d = '0;
        if (state_q == RECEBE && !receber_config && !shadowWe) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // Watchdog register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    // Select the previously stored threshold for the ascending-order check
    always_comb begin
        prevWord = '0;
        for (int k = 0; k < NUM_TEMP; k++) begin
            if (wordIndex_q == IDX_W'(k + 1)) begin
                prevWord = shadowTemp_q[k];
            end
        end
    end

    // Next-state logic: frame sequencing, word validation and error classification
    always_comb begin
        state_d     = state_q;
        wordIndex_d = wordIndex_q;
        erroCode_d  = erroCode_q;
        shadowWe    = 1'b0;
        shadowUmWe  = 1'b0;
        commitNow   = 1'b0;
        case (state_q)
            INICIAL: begin
                if (receber_config) begin
                    state_d     = RECEBE;
                    wordIndex_d = '0;
                    erroCode_d  = 2'd0;
                end
            end
            RECEBE: begin
                if (receber_config) begin
                    wordIndex_d = '0;
                end else if (word_valid) begin
                    if (!parity_ok) begin
                        state_d    = ERRO;
                        erroCode_d = 2'd1;
                    end else if (wordIndex_q == IDX_W'(NUM_TEMP)) begin
                        shadowUmWe = 1'b1;
                        state_d    = COMMIT;
                    end else if (wordIndex_q != '0 && word_data < prevWord) begin
                        state_d    = ERRO;
                        erroCode_d = 2'd3;
                    end else begin
                        shadowWe    = 1'b1;
                        wordIndex_d = wordIndex_q + IDX_W'(1);
                    end
                end
`ifdef CONFIG_TIMEOUT_EN
                else if (timerExpired) begin
                    state_d    = ERRO;
                    erroCode_d = 2'd2;
                end
`endif
            end
            COMMIT: begin
                commitNow = 1'b1;
                state_d   = INICIAL;
            end
            ERRO: begin
                if (receber_config) begin
                    state_d     = RECEBE;
                    wordIndex_d = '0;
                    erroCode_d  = 2'd0;
                end
            end
            default: state_d = INICIAL;
        endcase
    end

    // Control registers; pronto pulses in the first cycle of COMMIT or ERRO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= INICIAL;
            wordIndex_q <= '0;
            erroCode_q  <= 2'd0;
            pronto_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wordIndex_q <= wordIndex_d;
            erroCode_q  <= erroCode_d;
            pronto_q    <= (state_d == COMMIT) || (state_d == ERRO && state_q != ERRO);
        end
    end

    // Shadow registers capture accepted words until the frame is complete
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TEMP; k++) begin
                shadowTemp_q[k] <= '0;
            end
            shadowUm_q <= '0;
        end else begin
            for (int k = 0; k < NUM_TEMP; k++) begin
                if (shadowWe && wordIndex_q == IDX_W'(k)) begin
                    shadowTemp_q[k] <= word_data;
                end
            end
            if (shadowUmWe) begin
                shadowUm_q <= word_data;
            end
        end
    end

    // Active limits change only on COMMIT so the datapath never sees a partial frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            activeTemp_q  <= '0;
            activeUm_q    <= '0;
            configValid_q <= 1'b0;
        end else if (commitNow) begin
            for (int k = 0; k < NUM_TEMP; k++) begin
                activeTemp_q[k*WORD_W +: WORD_W] <= shadowTemp_q[k];
            end
            activeUm_q    <= shadowUm_q;
            configValid_q <= 1'b1;
        end
    end

    assign temp_limits   = activeTemp_q;
    assign lim_um        = activeUm_q;
    assign config_valid  = configValid_q;
    assign pronto_config = pronto_q;
    assign erro_config   = (state_q == ERRO);
    assign erro_code     = erroCode_q;
    assign word_index    = wordIndex_q;
    assign db_estado     = {2'b00, state_q};

endmodule

// File: tb/tb_config_manager_multi.sv
// Directed bench for config_manager_multi (NUM_TEMP=3, WORD_W=8, TIMEOUT_CYCLES=16).
// Timeout expectations follow whether CONFIG_TIMEOUT_EN is defined for the build.
module tb_config_manager_multi;

    localparam int NUM_TEMP       = 3;
    localparam int WORD_W         = 8;
    localparam int TIMEOUT_CYCLES = 16;

    logic                       clock;
    logic                       reset;
    logic                       receber_config;
    logic                       word_valid;
    logic [WORD_W-1:0]          word_data;
    logic                       parity_ok;
    logic [NUM_TEMP*WORD_W-1:0] temp_limits;
    logic [WORD_W-1:0]          lim_um;
    logic                       config_valid;
    logic                       pronto_config;
    logic                       erro_config;
    logic [1:0]                 erro_code;
    logic [1:0]                 word_index;
    logic [3:0]                 db_estado;

    int assertCount = 0;
    int failCount   = 0;
    int prontoCount = 0;

    config_manager_multi #(
        .NUM_TEMP       (NUM_TEMP),
        .WORD_W         (WORD_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .receber_config (receber_config),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .parity_ok      (parity_ok),
        .temp_limits    (temp_limits),
        .lim_um         (lim_um),
        .config_valid   (config_valid),
        .pronto_config  (pronto_config),
        .erro_config    (erro_config),
        .erro_code      (erro_code),
        .word_index     (word_index),
        .db_estado      (db_estado)
    );

    // Free-running 10-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count pronto pulses, sampled mid-cycle
    always @(negedge clock) begin
        if (pronto_config === 1'b1) prontoCount++;
    end

    // Global time guard so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic par);
        word_valid = 1'b1;
        word_data  = data;
        parity_ok  = par;
        tick();
        word_valid = 1'b0;
        parity_ok  = 1'b0;
    endtask

    task automatic startFrame();
        receber_config = 1'b1;
        tick();
        receber_config = 1'b0;
    endtask

    task automatic test_reset();
        assertCount++;
        if (temp_limits !== 24'h0) begin failCount++; $display("[TB] FAIL reset_temp: got %h expected %h", temp_limits, 24'h0); end
        assertCount++;
        if (lim_um !== 8'h0) begin failCount++; $display("[TB] FAIL reset_um: got %h expected %h", lim_um, 8'h0); end
        assertCount++;
        if ({config_valid, pronto_config, erro_config} !== 3'b000) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected %b", {config_valid, pronto_config, erro_config}, 3'b000); end
        assertCount++;
        if ({erro_code, word_index, db_estado} !== 8'h00) begin failCount++; $display("[TB] FAIL reset_status: got %h expected %h", {erro_code, word_index, db_estado}, 8'h00); end
        @(negedge clock);
        reset = 1'b1;
        tick();
        // word strobes are ignored while idle
        applyStimulus(8'h77, 1'b1);
        assertCount++;
        if ({word_index, db_estado} !== 6'h00) begin failCount++; $display("[TB] FAIL idle_ignore: got %h expected %h", {word_index, db_estado}, 6'h00); end
    endtask

    task automatic test_commit();
        prontoCount = 0;
        startFrame();
        assertCount++;
        if (db_estado !== 4'd1) begin failCount++; $display("[TB] FAIL enter_recebe: got %0d expected %0d", db_estado, 1); end
        applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h20, 1'b1);
        applyStimulus(8'h20, 1'b1);
        assertCount++;
        if (word_index !== 2'd3) begin failCount++; $display("[TB] FAIL index_after_temps: got %0d expected %0d", word_index, 3); end
        applyStimulus(8'h55, 1'b1);
        assertCount++;
        if ({db_estado, pronto_config} !== {4'd2, 1'b1}) begin failCount++; $display("[TB] FAIL commit_state: got %h expected %h", {db_estado, pronto_config}, {4'd2, 1'b1}); end
        assertCount++;
        if (temp_limits !== 24'h0) begin failCount++; $display("[TB] FAIL commit_not_early: got %h expected %h", temp_limits, 24'h0); end
        tick();
        assertCount++;
        if (temp_limits !== 24'h202010) begin failCount++; $display("[TB] FAIL commit_temp: got %h expected %h", temp_limits, 24'h202010); end
        assertCount++;
        if (lim_um !== 8'h55) begin failCount++; $display("[TB] FAIL commit_um: got %h expected %h", lim_um, 8'h55); end
        assertCount++;
        if ({config_valid, erro_config, pronto_config, db_estado} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin failCount++; $display("[TB] FAIL commit_flags: got %h expected %h", {config_valid, erro_config, pronto_config, db_estado}, {1'b1, 1'b0, 1'b0, 4'd0}); end
        tick();
        tick();
        assertCount++;
        if (prontoCount !== 1) begin failCount++; $display("[TB] FAIL commit_pulses: got %0d expected %0d", prontoCount, 1); end
    endtask

    task automatic test_parity();
        prontoCount = 0;
        startFrame();
        applyStimulus(8'h30, 1'b1);
        applyStimulus(8'h40, 1'b0);
        assertCount++;
        if ({db_estado, erro_config, erro_code} !== {4'd3, 1'b1, 2'd1}) begin failCount++; $display("[TB] FAIL parity_err: got %h expected %h", {db_estado, erro_config, erro_code}, {4'd3, 1'b1, 2'd1}); end
        tick();
        tick();
        tick();
        assertCount++;
        if (prontoCount !== 1) begin failCount++; $display("[TB] FAIL parity_pulses: got %0d expected %0d", prontoCount, 1); end
        assertCount++;
        if ({temp_limits, lim_um} !== {24'h202010, 8'h55}) begin failCount++; $display("[TB] FAIL parity_keep: got %h expected %h", {temp_limits, lim_um}, {24'h202010, 8'h55}); end
        assertCount++;
        if ({erro_config, erro_code, pronto_config} !== {1'b1, 2'd1, 1'b0}) begin failCount++; $display("[TB] FAIL parity_hold: got %h expected %h", {erro_config, erro_code, pronto_config}, {1'b1, 2'd1, 1'b0}); end
    endtask

    task automatic test_order();
        startFrame();
        assertCount++;
        if ({db_estado, erro_code, word_index} !== {4'd1, 2'd0, 2'd0}) begin failCount++; $display("[TB] FAIL restart_from_erro: got %h expected %h", {db_estado, erro_code, word_index}, {4'd1, 2'd0, 2'd0}); end
        applyStimulus(8'h30, 1'b1);
        applyStimulus(8'h20, 1'b1);
        assertCount++;
        if ({db_estado, erro_code} !== {4'd3, 2'd3}) begin failCount++; $display("[TB] FAIL order_err: got %h expected %h", {db_estado, erro_code}, {4'd3, 2'd3}); end
        startFrame();
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h04, 1'b1);
        tick();
        assertCount++;
        if ({temp_limits, lim_um} !== {24'h030201, 8'h04}) begin failCount++; $display("[TB] FAIL order_recover: got %h expected %h", {temp_limits, lim_um}, {24'h030201, 8'h04}); end
        assertCount++;
        if ({erro_code, erro_config, config_valid} !== {2'd0, 1'b0, 1'b1}) begin failCount++; $display("[TB] FAIL order_clear: got %h expected %h", {erro_code, erro_config, config_valid}, {2'd0, 1'b0, 1'b1}); end
    endtask

    task automatic test_timeout();
        logic [3:0] expState;
        logic [1:0] expCode;
`ifdef CONFIG_TIMEOUT_EN
        expState = 4'd3;
        expCode  = 2'd2;
`else
        expState = 4'd1;
        expCode  = 2'd0;
`endif
        startFrame();
        applyStimulus(8'h10, 1'b1);
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
        assertCount++;
        if (db_estado !== 4'd1) begin failCount++; $display("[TB] FAIL timeout_early: got %0d expected %0d", db_estado, 1); end
        tick();
        assertCount++;
        if ({db_estado, erro_code} !== {expState, expCode}) begin failCount++; $display("[TB] FAIL timeout_expire: got %h expected %h", {db_estado, erro_code}, {expState, expCode}); end
        // a word arriving in the last allowed cycle wins over the timeout
        startFrame();
        applyStimulus(8'h10, 1'b1);
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
        applyStimulus(8'h11, 1'b1);
        assertCount++;
        if ({db_estado, erro_code, word_index} !== {4'd1, 2'd0, 2'd2}) begin failCount++; $display("[TB] FAIL timeout_rescue: got %h expected %h", {db_estado, erro_code, word_index}, {4'd1, 2'd0, 2'd2}); end
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h99, 1'b1);
        tick();
        assertCount++;
        if ({temp_limits, lim_um} !== {24'h121110, 8'h99}) begin failCount++; $display("[TB] FAIL timeout_commit: got %h expected %h", {temp_limits, lim_um}, {24'h121110, 8'h99}); end
    endtask

    task automatic test_back_to_back();
        startFrame();
        applyStimulus(8'h05, 1'b1);
        applyStimulus(8'h06, 1'b1);
        // restart and a word strobe in the same cycle: restart wins
        receber_config = 1'b1;
        word_valid     = 1'b1;
        word_data      = 8'h07;
        parity_ok      = 1'b1;
        tick();
        receber_config = 1'b0;
        word_valid     = 1'b0;
        assertCount++;
        if ({word_index, db_estado} !== {2'd0, 4'd1}) begin failCount++; $display("[TB] FAIL restart_priority: got %h expected %h", {word_index, db_estado}, {2'd0, 4'd1}); end
        applyStimulus(8'h08, 1'b1);
        applyStimulus(8'h09, 1'b1);
        applyStimulus(8'h0A, 1'b1);
        applyStimulus(8'h44, 1'b1);
        tick();
        assertCount++;
        if ({temp_limits, lim_um} !== {24'h0A0908, 8'h44}) begin failCount++; $display("[TB] FAIL restart_commit: got %h expected %h", {temp_limits, lim_um}, {24'h0A0908, 8'h44}); end
    endtask

    task automatic test_reset_midframe();
        startFrame();
        applyStimulus(8'h50, 1'b1);
        #2;
        reset = 1'b0;
        #2;
        assertCount++;
        if ({temp_limits, lim_um} !== 32'h0) begin failCount++; $display("[TB] FAIL midreset_regs: got %h expected %h", {temp_limits, lim_um}, 32'h0); end
        assertCount++;
        if ({config_valid, pronto_config, erro_config, erro_code, word_index, db_estado} !== 11'h0) begin failCount++; $display("[TB] FAIL midreset_status: got %h expected %h", {config_valid, pronto_config, erro_config, erro_code, word_index, db_estado}, 11'h0); end
        @(negedge clock);
        reset = 1'b1;
        tick();
        assertCount++;
        if ({config_valid, db_estado} !== 5'h0) begin failCount++; $display("[TB] FAIL midreset_after: got %h expected %h", {config_valid, db_estado}, 5'h0); end
    endtask

    // Test sequence
    initial begin
        reset          = 1'b0;
        receber_config = 1'b0;
        word_valid     = 1'b0;
        word_data      = '0;
        parity_ok      = 1'b0;
        tick();
        tick();
        test_reset();
        test_commit();
        test_parity();
        test_order();
        test_timeout();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
